// File: rtl/btb_update_unit.sv
// -----------------------------------------------------------------------------
// btb_update_unit
//   Write-side companion to the branch target buffer. Every prediction that
//   decode acts on is recorded in an in-order tracking FIFO. When EX resolves
//   the oldest tracked branch, the recorded prediction is compared with the
//   actual outcome. The unit always issues the BTB write. On a misprediction it
//   also redirects fetch and squashes every younger tracked prediction.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   dec_push/pc/pred_taken/pred_target
//                     prediction registered by decode this cycle
//   res_valid/pc/taken/target
//                     resolution of the oldest tracked branch from EX
//   ext_flush         external pipeline flush; squashes all tracked entries
//   wr_en/pc/taken/target
//                     registered BTB write, a one-cycle pulse after a resolve
//   redirect/redirect_pc
//                     registered fetch redirect, a one-cycle pulse
//   stall             tracking FIFO full; decode must hold branches
//   count             number of entries tracked
//   mispredict_count  saturating total of mispredictions
//   err               sticky protocol error (overflow, empty resolve, PC mismatch)
// -----------------------------------------------------------------------------
module btb_update_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       dec_push,
  input  logic [31:0]                dec_pc,
  input  logic                       dec_pred_taken,
  input  logic [31:0]                dec_pred_target,
  input  logic                       res_valid,
  input  logic [31:0]                res_pc,
  input  logic                       res_taken,
  input  logic [31:0]                res_target,
  input  logic                       ext_flush,
  output logic                       wr_en,
  output logic [31:0]                wr_pc,
  output logic                       wr_taken,
  output logic [31:0]                wr_target,
  output logic                       redirect,
  output logic [31:0]                redirect_pc,
  output logic                       stall,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           mispredict_count,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] MC_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MC_ONE   = CNT_W'(1);

  // Tracking FIFO storage and pointers
  logic [31:0]      pc_mem_r   [DEPTH];
  logic             pt_mem_r   [DEPTH];
  logic [31:0]      tgt_mem_r  [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CW-1:0]    count_r;

  // Registered output state
  logic             wr_en_r;
  logic [31:0]      wr_pc_r;
  logic             wr_taken_r;
  logic [31:0]      wr_target_r;
  logic             redirect_r;
  logic [31:0]      redirect_pc_r;
  logic [CNT_W-1:0] mc_r;
  logic             err_r;

  // Per-cycle decisions
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             pc_bad_s;
  logic             mispred_s;
  logic             squash_s;
  logic             push_ok_s;
  logic             push_err_s;
  logic [31:0]      head_pc_s;
  logic             head_pt_s;
  logic [31:0]      head_tgt_s;
  logic [31:0]      fix_pc_s;

  assign stall = full_s;
  assign count = count_r;
  assign wr_en            = wr_en_r;
  assign wr_pc            = wr_pc_r;
  assign wr_taken         = wr_taken_r;
  assign wr_target        = wr_target_r;
  assign redirect         = redirect_r;
  assign redirect_pc      = redirect_pc_r;
  assign mispredict_count = mc_r;
  assign err              = err_r;

  // Compare the FIFO head against the resolution and decide push/pop/squash
  always_comb begin
    empty_s    = (count_r == {CW{1'b0}});
    full_s     = (count_r == FULL_CNT);
    head_pc_s  = pc_mem_r[rd_ptr_r];
    head_pt_s  = pt_mem_r[rd_ptr_r];
    head_tgt_s = tgt_mem_r[rd_ptr_r];
    pop_s      = res_valid && !empty_s;
    pc_bad_s   = pop_s && (res_pc != head_pc_s);
    // An empty resolve or a PC mismatch has no trustworthy prediction to
    // compare against, so it is handled as a misprediction.
    if (res_valid) begin
      mispred_s = empty_s || pc_bad_s || (head_pt_s != res_taken) ||
                  (res_taken && (head_tgt_s != res_target));
    end else begin
      mispred_s = 1'b0;
    end
    squash_s   = mispred_s || ext_flush;
    // A pop in the same cycle frees the slot, so pushing while full is legal.
    // Wrong-path pushes under a squash are dropped without raising err.
    push_ok_s  = dec_push && (!full_s || pop_s) && !squash_s;
    push_err_s = dec_push && full_s && !pop_s && !squash_s;
    fix_pc_s   = res_taken ? res_target : (res_pc + 32'd4);
  end

  // Tracking FIFO state: pointers, occupancy and entry storage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]  <= 32'd0;
        pt_mem_r[i]  <= 1'b0;
        tgt_mem_r[i] <= 32'd0;
      end
    end else if (squash_s) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_ok_s) begin
        pc_mem_r[wr_ptr_r]  <= dec_pc;
        pt_mem_r[wr_ptr_r]  <= dec_pred_taken;
        tgt_mem_r[wr_ptr_r] <= dec_pred_target;
        wr_ptr_r            <= wr_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // BTB write, redirect, mispredict counter and sticky error
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_en_r       <= 1'b0;
      wr_pc_r       <= 32'd0;
      wr_taken_r    <= 1'b0;
      wr_target_r   <= 32'd0;
      redirect_r    <= 1'b0;
      redirect_pc_r <= 32'd0;
      mc_r          <= {CNT_W{1'b0}};
      err_r         <= 1'b0;
    end else begin
      wr_en_r    <= pop_s;
      redirect_r <= mispred_s;
      if (pop_s) begin
        wr_pc_r     <= res_pc;
        wr_taken_r  <= res_taken;
        wr_target_r <= res_target;
      end
      if (mispred_s) begin
        redirect_pc_r <= fix_pc_s;
        if (mc_r != MC_MAX) begin
          mc_r <= mc_r + MC_ONE;
        end
      end
      if (push_err_s || (res_valid && empty_s) || pc_bad_s) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btb_update_unit.sv
module tb_btb_update_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int MC_MAX = (1 << CNT_W) - 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        dec_push = 1'b0;
  logic [31:0] dec_pc = 32'd0;
  logic        dec_pred_taken = 1'b0;
  logic [31:0] dec_pred_target = 32'd0;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = 32'd0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = 32'd0;
  logic        ext_flush = 1'b0;
  logic        wr_en;
  logic [31:0] wr_pc;
  logic        wr_taken;
  logic [31:0] wr_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [2:0]  count;
  logic [CNT_W-1:0] mispredict_count;
  logic        err;

  btb_update_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .dec_push(dec_push), .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken),
    .dec_pred_target(dec_pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .ext_flush(ext_flush),
    .wr_en(wr_en), .wr_pc(wr_pc), .wr_taken(wr_taken), .wr_target(wr_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .count(count), .mispredict_count(mispredict_count), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } pred_t;

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_pc;
    logic        wr_taken;
    logic [31:0] wr_target;
    logic        redirect;
    logic [31:0] redirect_pc;
  } exp_t;

  // Reference model state
  pred_t m_q[$];
  exp_t  sb[$];
  exp_t  m_hold;
  int    m_mc;
  logic  m_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    sb.delete();
    m_hold = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0};
    m_mc = 0;
    m_err = 1'b0;
  endtask

  // One clock of stimulus: compute expectations, drive, then compare
  task automatic step(input logic dp, input logic [31:0] dpc, input logic dpt,
                      input logic [31:0] dtg, input logic rv, input logic [31:0] rpc,
                      input logic rt, input logic [31:0] rtg, input logic fl);
    bit    empty, full, pop, mis;
    pred_t head;
    exp_t  e;
    exp_t  got;
    empty = (m_q.size() == 0);
    full  = (m_q.size() == DEPTH);
    pop   = rv && !empty;
    mis   = 1'b0;
    if (pop) begin
      head = m_q[0];
      mis = (head.pc != rpc) || (head.pt != rt) || (rt && head.tgt != rtg);
      if (head.pc != rpc) m_err = 1'b1;
    end
    if (rv && empty) begin
      mis = 1'b1;
      m_err = 1'b1;
    end
    e = m_hold;
    e.wr_en = pop;
    e.redirect = mis;
    if (pop) begin
      e.wr_pc = rpc; e.wr_taken = rt; e.wr_target = rtg;
    end
    if (mis) e.redirect_pc = rt ? rtg : rpc + 32'd4;
    m_hold = e;
    sb.push_back(e);
    if (dp && full && !pop && !mis && !fl) m_err = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (mis || fl) m_q.delete();
    else if (dp && (!full || pop)) m_q.push_back('{dpc, dpt, dtg});
    if (mis && m_mc < MC_MAX) m_mc++;

    @(negedge CLK);
    dec_push = dp; dec_pc = dpc; dec_pred_taken = dpt; dec_pred_target = dtg;
    res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg; ext_flush = fl;
    @(posedge CLK);
    #1;
    got = sb.pop_front();
    chk("wr_en", {31'd0, wr_en}, {31'd0, got.wr_en});
    chk("wr_pc", wr_pc, got.wr_pc);
    chk("wr_taken", {31'd0, wr_taken}, {31'd0, got.wr_taken});
    chk("wr_target", wr_target, got.wr_target);
    chk("redirect", {31'd0, redirect}, {31'd0, got.redirect});
    chk("redirect_pc", redirect_pc, got.redirect_pc);
    chk("count", {29'd0, count}, m_q.size());
    chk("stall", {31'd0, stall}, {31'd0, (m_q.size() == DEPTH)});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("mispredict_count", {24'd0, mispredict_count}, m_mc);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
    step(1'b1, pc, pt, tg, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, pc, t, tg, 1'b0);
  endtask

  // Reset asserted while a resolve is being driven; everything must clear
  task automatic rst_pulse();
    @(negedge CLK);
    res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1; res_target = 32'h80;
    dec_push = 1'b1; dec_pc = 32'h999;
    #2 RST = 1'b1;
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    @(posedge CLK);
    #1;
    chk("rst_wr_pc", wr_pc, 32'd0);
    chk("rst_wr_target", wr_target, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mc", {24'd0, mispredict_count}, 32'd0);
    @(negedge CLK);
    res_valid = 1'b0; dec_push = 1'b0;
    RST = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    chk("init_count", {29'd0, count}, 32'd0);
    chk("init_wr_en", {31'd0, wr_en}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Reset mid-stream with two entries tracked
    push(32'h40, 1'b1, 32'h80);
    push(32'h44, 1'b0, 32'h0);
    rst_pulse();
    idle();

    // Correct taken prediction
    push(32'h40, 1'b1, 32'h80);
    resolve(32'h40, 1'b1, 32'h80);

    // Direction mispredict squashes younger entries
    push(32'h100, 1'b1, 32'h180);
    push(32'h104, 1'b0, 32'h0);
    push(32'h108, 1'b0, 32'h0);
    resolve(32'h100, 1'b0, 32'h180);
    idle();

    // Target mispredict
    push(32'h200, 1'b1, 32'h300);
    resolve(32'h200, 1'b1, 32'h340);

    // Not-taken prediction correct; target passed through unchanged
    push(32'h210, 1'b0, 32'h0);
    resolve(32'h210, 1'b0, 32'h5555);

    // Fill, then overflow push
    rst_pulse();
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'd0);
    push(32'h1010, 1'b0, 32'd0);

    // Fill, then push with correct resolve in the same cycle
    rst_pulse();
    for (int i = 0; i < DEPTH; i++) push(32'h2000 + 32'(i * 4), 1'b1, 32'h3000 + 32'(i));
    step(1'b1, 32'h2010, 1'b0, 32'd0, 1'b1, 32'h2000, 1'b1, 32'h3000, 1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      if (i < DEPTH) resolve(32'h2000 + 32'(i * 4), 1'b1, 32'h3000 + 32'(i));
      else           resolve(32'h2010, 1'b0, 32'd0);
    end

    // External flush with same-cycle resolve and push
    push(32'h400, 1'b0, 32'd0);
    push(32'h404, 1'b0, 32'd0);
    step(1'b1, 32'h408, 1'b0, 32'd0, 1'b1, 32'h400, 1'b0, 32'd0, 1'b1);
    idle();

    // PC mismatch is an error and a mispredict
    rst_pulse();
    push(32'h500, 1'b0, 32'd0);
    resolve(32'h504, 1'b0, 32'd0);

    // Resolve with the FIFO empty
    rst_pulse();
    resolve(32'h600, 1'b0, 32'd0);
    resolve(32'hFFFF_FFFC, 1'b0, 32'd0);

    // Saturate the mispredict counter
    rst_pulse();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      push(32'h8000 + 32'(i * 4), 1'b0, 32'd0);
      resolve(32'h8000 + 32'(i * 4), 1'b1, 32'h9000);
    end
    chk("mc_saturated", {24'd0, mispredict_count}, MC_MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
